// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter sequencer.
//   pc_state_e : sequencer state (run, halted, faulted)
//   pc_sel_e   : next-PC source select
//   PC_AW_DEFAULT : default PC/address width
package pc_pkg;

  localparam int unsigned PC_AW_DEFAULT = 8;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_HALT  = 2'd1,
    PC_FAULT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_JUMP = 2'd2,
    SEL_RET  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: LIFO of return addresses for call/ret.
//   clk, rst_n : clock, async active-low reset (clears the pointer only)
//   push, pop  : push din / pop top; push ignored when full, pop when empty
//   din, dout  : address in / current top of stack (valid when !empty)
//   full, empty: occupancy flags
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int unsigned AW          = PC_AW_DEFAULT,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0] mem [STACK_DEPTH];
  logic [PW-1:0] sp_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (sp_q == PW'(STACK_DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // sp_q counts entries, so the top lives one below it.
  assign wr_idx  = IW'(sp_q);
  assign rd_idx  = IW'(sp_q - PW'(1));
  assign dout    = mem[rd_idx];

  // Entry storage is not reset; only the pointer defines what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sp_q <= '0;
    else if (do_push) sp_q <= sp_q + PW'(1);
    else if (do_pop)  sp_q <= sp_q - PW'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selector for the 8-bit core with stall, halt/resume,
// optional call/return stack and fault detection.
// Build option: PC_CALL_STACK_EN enables the return stack; without it call
// acts as an unconditional jump, ret is ignored (pc+1) and the stack flags
// read 0.
//   clk, rst_n   : clock, async active-low reset
//   stall        : hold all state this cycle
//   halt_req     : enter HALT; resume leaves HALT
//   jmp_uncond   : jump to jump_addr; jmp_cond jumps iff cond_status
//   call, ret    : push pc+1 and jump / pop into pc
//   jump_addr    : jump/call target
//   pc, pc_valid : current PC, high in RUN when not stalled
//   halted, fault: state indicators; stack_ovf/stack_unf sticky flags
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned    AW           = PC_AW_DEFAULT,
  parameter int unsigned    STACK_DEPTH  = 4,
  parameter logic [AW-1:0]  RESET_VECTOR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          resume,
  input  logic          jmp_uncond,
  input  logic          jmp_cond,
  input  logic          cond_status,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] pc,
  output logic          pc_valid,
  output logic          halted,
  output logic          fault,
  output logic          stack_ovf,
  output logic          stack_unf
);

  pc_state_e     state_q, state_d;
  pc_sel_e       sel;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] ret_addr;

  assign pc_inc = pc_q + AW'(1);

`ifdef PC_CALL_STACK_EN
  logic stk_push, stk_pop, stk_full, stk_empty;
  logic ovf_set, unf_set, ovf_q, unf_q;

  pc_return_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (ret_addr),
    .full  (stk_full),
    .empty (stk_empty)
  );
`else
  assign ret_addr = '0;
`endif

  always_comb begin
    sel     = SEL_HOLD;
    state_d = state_q;
`ifdef PC_CALL_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
`endif
    case (state_q)
      PC_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = PC_HALT;
          end else if (ret) begin
`ifdef PC_CALL_STACK_EN
            if (stk_empty) begin
              unf_set = 1'b1;
              state_d = PC_FAULT;
            end else begin
              sel     = SEL_RET;
              stk_pop = 1'b1;
            end
`else
            sel = SEL_INC;
`endif
          end else if (call) begin
`ifdef PC_CALL_STACK_EN
            if (stk_full) begin
              ovf_set = 1'b1;
              state_d = PC_FAULT;
            end else begin
              sel      = SEL_JUMP;
              stk_push = 1'b1;
            end
`else
            sel = SEL_JUMP;
`endif
          end else if (jmp_uncond || (jmp_cond && cond_status)) begin
            sel = SEL_JUMP;
          end else begin
            sel = SEL_INC;
          end
        end
      end
      PC_HALT: begin
        // halt_req wins over resume so a simultaneous pair keeps us halted.
        if (!stall && resume && !halt_req) state_d = PC_RUN;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_INC:  pc_d = pc_inc;
      SEL_JUMP: pc_d = jump_addr;
      SEL_RET:  pc_d = ret_addr;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PC_RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_valid = (state_q == PC_RUN) && !stall;
  assign halted   = (state_q == PC_HALT);
  assign fault    = (state_q == PC_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer (AW=8, depth 4).
// Expected outputs are queued as each cycle's stimulus is driven; the
// observed outputs after the edge are queued alongside and each test task
// drains both queues and compares.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, stall, halt_req, resume, jmp_uncond, jmp_cond;
  logic       cond_status, call, ret;
  logic [7:0] jump_addr;
  logic [7:0] pc;
  logic       pc_valid, halted, fault, stack_ovf, stack_unf;

  typedef struct packed {
    logic [7:0] pc;
    logic       halted;
    logic       fault;
    logic       ovf;
    logic       unf;
  } obs_t;

  obs_t exp_q[$];
  obs_t act_q[$];
  int   total = 0;
  int   bad   = 0;

  pc_sequencer #(
    .AW           (8),
    .STACK_DEPTH  (4),
    .RESET_VECTOR (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .halt_req    (halt_req),
    .resume      (resume),
    .jmp_uncond  (jmp_uncond),
    .jmp_cond    (jmp_cond),
    .cond_status (cond_status),
    .call        (call),
    .ret         (ret),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .halted      (halted),
    .fault       (fault),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    stall = 0; halt_req = 0; resume = 0; jmp_uncond = 0; jmp_cond = 0;
    cond_status = 0; call = 0; ret = 0; jump_addr = 8'h00;
  endtask

  // Queue the expected outcome of the current stimulus, clock once, capture.
  task automatic cycle(input logic [7:0] epc, input logic eh, input logic ef,
                       input logic eo, input logic eu);
    obs_t e, a;
    e = '{pc: epc, halted: eh, fault: ef, ovf: eo, unf: eu};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    a = '{pc: pc, halted: halted, fault: fault, ovf: stack_ovf, unf: stack_unf};
    act_q.push_back(a);
  endtask

  task automatic jump_to(input logic [7:0] addr);
    clr(); jmp_uncond = 1; jump_addr = addr;
    cycle(addr, 0, 0, 0, 0);
    clr();
  endtask

  task automatic test_reset();
    clr();
    rst_n = 0;
    #3;
    total++;
    if ({pc, halted, fault, stack_ovf, stack_unf} !== {8'h00, 4'b0000}) begin
      bad++;
      $display("FAIL reset: pc=%h h=%b f=%b o=%b u=%b want pc=00 flags=0",
               pc, halted, fault, stack_ovf, stack_unf);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    total++;
    if (pc_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_valid: pc_valid=%b want 1", pc_valid);
    end
  endtask

  task automatic test_free_run();
    obs_t e, a;
    clr();
    for (int i = 1; i <= 3; i++) cycle(8'(i), 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL free_run: got pc=%h h%b f%b o%b u%b want pc=%h h%b f%b o%b u%b",
                 a.pc, a.halted, a.fault, a.ovf, a.unf, e.pc, e.halted, e.fault, e.ovf, e.unf);
      end
    end
    total++;
    if (pc_valid !== 1'b1) begin
      bad++;
      $display("FAIL free_run_valid: pc_valid=%b want 1", pc_valid);
    end
  endtask

  task automatic test_wrap();
    obs_t e, a;
    jump_to(8'hFE);
    cycle(8'hFF, 0, 0, 0, 0);
    cycle(8'h00, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL wrap: got pc=%h h%b f%b o%b u%b want pc=%h h%b f%b o%b u%b",
                 a.pc, a.halted, a.fault, a.ovf, a.unf, e.pc, e.halted, e.fault, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_cond_and_stall();
    obs_t e, a;
    logic v;
    jump_to(8'h10);
    jmp_cond = 1; cond_status = 0; jump_addr = 8'h40;
    cycle(8'h11, 0, 0, 0, 0);
    cond_status = 1;
    cycle(8'h40, 0, 0, 0, 0);
    clr(); stall = 1; jmp_uncond = 1; jump_addr = 8'h77;
    cycle(8'h40, 0, 0, 0, 0);
    v = pc_valid;
    // Dropped, not queued: releasing stall without strobes just increments.
    clr();
    cycle(8'h41, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cond_stall: got pc=%h h%b f%b o%b u%b want pc=%h h%b f%b o%b u%b",
                 a.pc, a.halted, a.fault, a.ovf, a.unf, e.pc, e.halted, e.fault, e.ovf, e.unf);
      end
    end
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL stall_valid: pc_valid=%b want 0", v);
    end
  endtask

  task automatic test_call_ret();
    obs_t e, a;
    jump_to(8'h20);
    call = 1; jump_addr = 8'h80;
    cycle(8'h80, 0, 0, 0, 0);
    clr();
    cycle(8'h81, 0, 0, 0, 0);
    cycle(8'h82, 0, 0, 0, 0);
    ret = 1;
`ifdef PC_CALL_STACK_EN
    cycle(8'h21, 0, 0, 0, 0);
`else
    cycle(8'h83, 0, 0, 0, 0);
`endif
    // ret outranks call and jumps issued alongside it.
    clr(); call = 1; jmp_uncond = 1; jump_addr = 8'h90;
    cycle(8'h90, 0, 0, 0, 0);
    clr(); ret = 1; jmp_uncond = 1; jump_addr = 8'h55;
`ifdef PC_CALL_STACK_EN
    cycle(8'h22, 0, 0, 0, 0);
`else
    cycle(8'h91, 0, 0, 0, 0);
`endif
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL call_ret: got pc=%h h%b f%b o%b u%b want pc=%h h%b f%b o%b u%b",
                 a.pc, a.halted, a.fault, a.ovf, a.unf, e.pc, e.halted, e.fault, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_overflow_and_underflow();
    obs_t e, a;
    logic v;
    jump_to(8'h50);
    for (int i = 1; i <= 4; i++) begin
      call = 1; jump_addr = 8'(8'h50 + 16 * i);
      cycle(8'(8'h50 + 16 * i), 0, 0, 0, 0);
    end
    call = 1; jump_addr = 8'hA0;
`ifdef PC_CALL_STACK_EN
    cycle(8'h90, 0, 1, 1, 0);
    clr(); jmp_uncond = 1; jump_addr = 8'h11;
    cycle(8'h90, 0, 1, 1, 0);
    clr(); resume = 1;
    cycle(8'h90, 0, 1, 1, 0);
`else
    cycle(8'hA0, 0, 0, 0, 0);
    clr(); jmp_uncond = 1; jump_addr = 8'h11;
    cycle(8'h11, 0, 0, 0, 0);
    clr(); resume = 1;
    cycle(8'h12, 0, 0, 0, 0);
`endif
    clr();
    v = pc_valid;
    // Mid-operation reset off the clock edge; stack must come back empty.
    #2 rst_n = 0;
    #1;
    a = '{pc: pc, halted: halted, fault: fault, ovf: stack_ovf, unf: stack_unf};
    e = '{pc: 8'h00, halted: 0, fault: 0, ovf: 0, unf: 0};
    exp_q.push_back(e); act_q.push_back(a);
    @(negedge clk);
    rst_n = 1;
    ret = 1;
`ifdef PC_CALL_STACK_EN
    cycle(8'h00, 0, 1, 0, 1);
`else
    cycle(8'h01, 0, 0, 0, 0);
`endif
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ovf_unf: got pc=%h h%b f%b o%b u%b want pc=%h h%b f%b o%b u%b",
                 a.pc, a.halted, a.fault, a.ovf, a.unf, e.pc, e.halted, e.fault, e.ovf, e.unf);
      end
    end
    total++;
`ifdef PC_CALL_STACK_EN
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL fault_valid: pc_valid=%b want 0", v);
    end
`else
    if (v !== 1'b1) begin
      bad++;
      $display("FAIL fault_valid: pc_valid=%b want 1", v);
    end
`endif
    // Leave a clean RUN state for later tests.
    rst_n = 0;
    #1 rst_n = 1;
  endtask

  task automatic test_halt();
    obs_t e, a;
    jump_to(8'h33);
    halt_req = 1;
    cycle(8'h33, 1, 0, 0, 0);
    clr(); jmp_uncond = 1; call = 1; ret = 1; jump_addr = 8'h55;
    cycle(8'h33, 1, 0, 0, 0);
    clr(); halt_req = 1; resume = 1;
    cycle(8'h33, 1, 0, 0, 0);
    clr(); stall = 1; resume = 1;
    cycle(8'h33, 1, 0, 0, 0);
    clr(); resume = 1;
    cycle(8'h33, 0, 0, 0, 0);
    clr();
    cycle(8'h34, 0, 0, 0, 0);
    // halt_req outranks a jump issued alongside it.
    halt_req = 1; jmp_uncond = 1; jump_addr = 8'hEE;
    cycle(8'h34, 1, 0, 0, 0);
    clr(); resume = 1;
    cycle(8'h34, 0, 0, 0, 0);
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL halt: got pc=%h h%b f%b o%b u%b want pc=%h h%b f%b o%b u%b",
                 a.pc, a.halted, a.fault, a.ovf, a.unf, e.pc, e.halted, e.fault, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    logic [7:0] tgt [4];
    tgt[0] = 8'hC0; tgt[1] = 8'hC8; tgt[2] = 8'h05; tgt[3] = 8'hFF;
    clr();
    for (int i = 0; i < 4; i++) begin
      if (i[0]) begin jmp_uncond = 0; jmp_cond = 1; cond_status = 1; end
      else      begin jmp_uncond = 1; jmp_cond = 0; cond_status = 0; end
      jump_addr = tgt[i];
      cycle(tgt[i], 0, 0, 0, 0);
    end
    clr();
    cycle(8'h00, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL back_to_back: got pc=%h h%b f%b o%b u%b want pc=%h h%b f%b o%b u%b",
                 a.pc, a.halted, a.fault, a.ovf, a.unf, e.pc, e.halted, e.fault, e.ovf, e.unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_wrap();
    test_cond_and_stall();
    test_call_ret();
    test_overflow_and_underflow();
    @(posedge clk); #1;
    test_halt();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
